simd_seq_ctrl: RTL and testbench
================================

Name: simd_seq_ctrl

Overview:
Program sequencer for the SIMD matrix engine. It fetches 32-bit instructions from instruction memory, decodes the opcode, and drives the load-B, load-A, MAC and write-back step strobes. Each of these steps runs for N beats with a datapath index. It sits between instruction memory and the CFU/AB register-file datapath and replaces bench-driven INSTRDATA/PC_Counter stimulus.

Parameters:
N, 16, SIMD lanes and beats per matrix op
LogN, $clog2(N), width of beat index
PC_W, 8, instruction address width (REGN/2 = 256 words)

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous, active-high reset
START  in  1  one-cycle pulse; begin program at address 0 (ignored unless IDLE)
PC_INS  out  PC_W  instruction address
INSTRDATA  in  32  instruction word, valid one cycle after PC_INS (synchronous ROM)
DP_READY  in  1  datapath may accept a beat this cycle
SEQ_IDX  out  LogN  current beat index (row/column)
LOAD_B  out  1  MATB column transfer beat
LOAD_A  out  1  MATA row transfer beat
MAC_EN  out  1  multiply-accumulate beat
MAC_CLR  out  1  clear accumulators (first MAC beat only)
WRITE_MAT  out  1  write-back beat
BUSY  out  1  high in any state except IDLE/HALT/ERR
DONE  out  1  one-cycle pulse on END
ERR  out  1  sticky illegal-opcode / PC-overflow flag

Behaviour:
- Reset: state IDLE, PC_INS=0, SEQ_IDX=0, all strobes 0, BUSY=0, DONE=0, ERR=0. Reset mid-operation aborts immediately to these values.
- States: IDLE, FETCH, DECODE, EXEC, HALT, ERRS.
- IDLE: on START go to FETCH with PC_INS=0.
- FETCH (1 cycle): PC_INS is held; go to DECODE.
- DECODE: sample INSTRDATA[7:0].
  - 0x09 = LOADB, 0x0A = LOADA, 0x03 = MATMUL, 0x04 = WB: latch op, SEQ_IDX=0, go to EXEC.
  - 0x80 = END: pulse DONE for one cycle, go to HALT.
  - Any other value: set ERR, go to ERRS.
  - INSTRDATA[31:8] is ignored.
- EXEC: the op's strobe equals DP_READY, combinationally.
  - Beat occurs when DP_READY=1: SEQ_IDX increments.
  - DP_READY=0: hold SEQ_IDX, strobe low (stall, no timeout).
  - MAC_CLR = MAC_EN && SEQ_IDX==0.
  - On the beat with SEQ_IDX==N-1: SEQ_IDX wraps to 0. If PC_INS==2^PC_W-1, set ERR and go to ERRS. Otherwise increment PC_INS and go to FETCH.
- Only one strobe is ever high at a time.
- Latency: START at cycle 0 -> FETCH cycle 1 -> DECODE cycle 2 -> first beat cycle 3 (DP_READY=1). An op with no stalls takes N+2 cycles including fetch/decode.
- HALT, ERRS: outputs idle, PC_INS holds. START returns to FETCH at PC 0. In ERRS, START also clears ERR. In HALT, ERR is unchanged.
- START while BUSY is ignored. START in the same cycle as reset: reset wins.

Optional Feature:
SIMD_SEQ_PERF_EN
- Defined: adds output PERF_CYC [31:0] and PERF_STALL [15:0].
  - PERF_CYC counts cycles with BUSY=1.
  - PERF_STALL counts EXEC cycles with DP_READY=0.
  - Both saturate, clear on reset and on accepted START, and freeze in HALT/ERRS.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset check: assert RSTN during an EXEC op → all outputs drop to reset values asynchronously; release and pulse START → fetch restarts at PC 0.
- Program [0x09, 0x0A, 0x03, 0x04, 0x80], DP_READY=1 → each of LOAD_B, LOAD_A, MAC_EN, WRITE_MAT is high for 16 cycles with SEQ_IDX 0..15; MAC_CLR is high once; DONE pulses at cycle 5*18-16+1 after START; BUSY drops with DONE.
- MATMUL with DP_READY low for 3 cycles at SEQ_IDX=7 → SEQ_IDX holds 7, MAC_EN low for those cycles; the op ends 3 cycles later; PERF_STALL=3 when SIMD_SEQ_PERF_EN is defined.
- Opcode 0x55 at PC 2 → ERR=1, state ERRS, PC_INS=2, no strobes; START → ERR clears and fetch restarts at 0.
- 256 consecutive 0x09 words with no END → ERR sets after the last beat at PC 255, with no wrap to 0.
- START pulsed while BUSY → ignored; SEQ_IDX/PC progression is unchanged versus the reference run.

Source files
------------

// File: rtl/simd_seq_if.sv
// Handshake bundle between the SIMD program sequencer, instruction ROM and datapath.
// PERF_CYC/PERF_STALL exist only when SIMD_SEQ_PERF_EN is defined.
interface simd_seq_if #(
  parameter int N    = 16,
  parameter int LogN = $clog2(N),
  parameter int PC_W = 8
);
  logic            START;
  logic [PC_W-1:0] PC_INS;
  logic [31:0]     INSTRDATA;
  logic            DP_READY;
  logic [LogN-1:0] SEQ_IDX;
  logic            LOAD_B;
  logic            LOAD_A;
  logic            MAC_EN;
  logic            MAC_CLR;
  logic            WRITE_MAT;
  logic            BUSY;
  logic            DONE;
  logic            ERR;
`ifdef SIMD_SEQ_PERF_EN
  logic [31:0]     PERF_CYC;
  logic [15:0]     PERF_STALL;
`endif

  modport master (
    input  START, INSTRDATA, DP_READY,
    output PC_INS, SEQ_IDX, LOAD_B, LOAD_A, MAC_EN, MAC_CLR, WRITE_MAT,
    output BUSY, DONE, ERR
`ifdef SIMD_SEQ_PERF_EN
    , output PERF_CYC, PERF_STALL
`endif
  );

  modport slave (
    output START, INSTRDATA, DP_READY,
    input  PC_INS, SEQ_IDX, LOAD_B, LOAD_A, MAC_EN, MAC_CLR, WRITE_MAT,
    input  BUSY, DONE, ERR
`ifdef SIMD_SEQ_PERF_EN
    , input PERF_CYC, PERF_STALL
`endif
  );
endinterface

// File: rtl/simd_seq_ctrl.sv
// Program sequencer for the SIMD matrix engine: fetch/decode/execute of N-beat ops.
// Optional busy/stall performance counters are enabled by defining SIMD_SEQ_PERF_EN.
module simd_seq_ctrl #(
  parameter int N    = 16,
  parameter int LogN = $clog2(N),
  parameter int PC_W = 8
) (
  input  logic        CLK,
  input  logic        RSTN,
  simd_seq_if.master  bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_ERRS   = 3'd5;

  localparam logic [7:0] OPC_LOADB  = 8'h09;
  localparam logic [7:0] OPC_LOADA  = 8'h0A;
  localparam logic [7:0] OPC_MATMUL = 8'h03;
  localparam logic [7:0] OPC_WB     = 8'h04;
  localparam logic [7:0] OPC_END    = 8'h80;

  localparam logic [1:0] OP_LB = 2'd0;
  localparam logic [1:0] OP_LA = 2'd1;
  localparam logic [1:0] OP_MM = 2'd2;
  localparam logic [1:0] OP_WB = 2'd3;

  logic [2:0]      state;
  logic [1:0]      op;
  logic [PC_W-1:0] pc;
  logic [LogN-1:0] idx;
  logic            done_q;
  logic            err_q;
  logic            exec;
  logic            start_acc;
  logic            last_beat;
  logic            unused_instr_hi;

  assign exec      = (state == S_EXEC);
  assign start_acc = bus.START && (state == S_IDLE || state == S_HALT || state == S_ERRS);
  assign last_beat = (idx == LogN'(N - 1));
  // Upper instruction bits carry operands for the datapath, not the sequencer.
  assign unused_instr_hi = ^bus.INSTRDATA[31:8];

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state  <= S_IDLE;
      op     <= OP_LB;
      pc     <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_HALT, S_ERRS: begin
          if (bus.START) begin
            state <= S_FETCH;
            pc    <= '0;
            if (state == S_ERRS) err_q <= 1'b0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          idx <= '0;
          case (bus.INSTRDATA[7:0])
            OPC_LOADB:  begin op <= OP_LB; state <= S_EXEC; end
            OPC_LOADA:  begin op <= OP_LA; state <= S_EXEC; end
            OPC_MATMUL: begin op <= OP_MM; state <= S_EXEC; end
            OPC_WB:     begin op <= OP_WB; state <= S_EXEC; end
            OPC_END:    begin done_q <= 1'b1; state <= S_HALT; end
            default:    begin err_q <= 1'b1; state <= S_ERRS; end
          endcase
        end
        S_EXEC: begin
          if (bus.DP_READY) begin
            if (last_beat) begin
              idx <= '0;
              // The last program word cannot fall through to address 0.
              if (pc == {PC_W{1'b1}}) begin
                err_q <= 1'b1;
                state <= S_ERRS;
              end else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.PC_INS    = pc;
  assign bus.SEQ_IDX   = idx;
  assign bus.LOAD_B    = exec && (op == OP_LB) && bus.DP_READY;
  assign bus.LOAD_A    = exec && (op == OP_LA) && bus.DP_READY;
  assign bus.MAC_EN    = exec && (op == OP_MM) && bus.DP_READY;
  assign bus.MAC_CLR   = bus.MAC_EN && (idx == '0);
  assign bus.WRITE_MAT = exec && (op == OP_WB) && bus.DP_READY;
  assign bus.BUSY      = (state == S_FETCH) || (state == S_DECODE) || exec;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

`ifdef SIMD_SEQ_PERF_EN
  logic [31:0] perf_cyc;
  logic [15:0] perf_stall;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counters only move while BUSY, so they freeze in HALT/ERRS by construction.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      perf_cyc   <= '0;
      perf_stall <= '0;
    end else if (start_acc) begin
      perf_cyc   <= '0;
      perf_stall <= '0;
    end else begin
      if (bus.BUSY) perf_cyc <= sat_inc32(perf_cyc);
      if (exec && !bus.DP_READY) perf_stall <= sat_inc16(perf_stall);
    end
  end

  assign bus.PERF_CYC   = perf_cyc;
  assign bus.PERF_STALL = perf_stall;
`endif
endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Directed bench for simd_seq_ctrl with a synchronous-ROM model of instruction memory.
module tb_simd_seq_ctrl;
  localparam int N    = 16;
  localparam int PC_W = 8;

  logic        CLK;
  logic        RSTN;
  logic [31:0] rom [256];
  int          checks;
  int          errors;

  simd_seq_if #(.N(N), .PC_W(PC_W)) bus ();
  simd_seq_ctrl #(.N(N), .PC_W(PC_W)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) bus.INSTRDATA <= rom[bus.PC_INS];

  // Output bits: [7]LOAD_B [6]LOAD_A [5]MAC_EN [4]MAC_CLR [3]WRITE_MAT [2]BUSY [1]DONE [0]ERR
  function automatic logic [7:0] outs();
    return {bus.LOAD_B, bus.LOAD_A, bus.MAC_EN, bus.MAC_CLR, bus.WRITE_MAT,
            bus.BUSY, bus.DONE, bus.ERR};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  task automatic load_prog();
    clear_rom();
    rom[0] = 32'h0000_0009;
    rom[1] = 32'h0000_000A;
    rom[2] = 32'h0000_0003;
    rom[3] = 32'h0000_0004;
    rom[4] = 32'h0000_0080;
  endtask

  task automatic pulse_start();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    bus.START = 1'b0;
    bus.DP_READY = 1'b1;
    RSTN = 1'b1;
    tick();
    o = outs();
    checks++;
    if (o !== 8'h00 || bus.PC_INS !== 8'd0 || bus.SEQ_IDX !== 4'd0) begin
      errors++;
      $display("FAIL reset_init outs=%h pc=%0d idx=%0d required outs=00 pc=0 idx=0",
               o, bus.PC_INS, bus.SEQ_IDX);
    end
    RSTN = 1'b0;
    load_prog();
    pulse_start();
    for (int c = 1; c < 10; c++) tick();
    o = outs();
    checks++;
    if (o !== 8'h84 || bus.SEQ_IDX !== 4'd7) begin
      errors++;
      $display("FAIL reset_preabort outs=%h idx=%0d required outs=84 idx=7", o, bus.SEQ_IDX);
    end
    RSTN = 1'b1;
    #1;
    o = outs();
    checks++;
    if (o !== 8'h00 || bus.PC_INS !== 8'd0 || bus.SEQ_IDX !== 4'd0) begin
      errors++;
      $display("FAIL reset_async outs=%h pc=%0d idx=%0d required outs=00 pc=0 idx=0",
               o, bus.PC_INS, bus.SEQ_IDX);
    end
    bus.START = 1'b1;
    tick();
    RSTN = 1'b0;
    bus.START = 1'b0;
    tick();
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start busy=%b required 0", bus.BUSY);
    end
    pulse_start();
    o = outs();
    checks++;
    if (o !== 8'h04 || bus.PC_INS !== 8'd0) begin
      errors++;
      $display("FAIL reset_restart_fetch outs=%h pc=%0d required outs=04 pc=0", o, bus.PC_INS);
    end
    tick();
    tick();
    o = outs();
    checks++;
    if (o !== 8'h84 || bus.SEQ_IDX !== 4'd0) begin
      errors++;
      $display("FAIL reset_restart_beat outs=%h idx=%0d required outs=84 idx=0", o, bus.SEQ_IDX);
    end
    RSTN = 1'b1;
    tick();
    RSTN = 1'b0;
  endtask

  // Full five-word program; optional stray START pulses while BUSY must change nothing.
  task automatic test_program(input bit inject_start);
    logic [7:0] o, eo;
    int k, p, eidx, epc, nb;
    load_prog();
    bus.DP_READY = 1'b1;
    pulse_start();
    nb = 0;
    for (int c = 1; c <= 78; c++) begin
      bus.START = inject_start && (c == 5 || c == 19 || c == 20 || c == 40 || c == 74);
      #1;
      eo = 8'h00; eidx = 0; epc = 4;
      if (c <= 74) begin
        k = (c - 1) / 18;
        p = (c - 1) % 18;
        eo[2] = 1'b1;
        epc = k;
        if (k < 4 && p >= 2) begin
          eidx = p - 2;
          case (k)
            0: eo[7] = 1'b1;
            1: eo[6] = 1'b1;
            2: begin eo[5] = 1'b1; eo[4] = (p == 2); end
            default: eo[3] = 1'b1;
          endcase
        end
      end else if (c == 75) begin
        eo[1] = 1'b1;
      end
      o = outs();
      if (o[7] | o[6] | o[5] | o[3]) nb++;
      checks++;
      if (o !== eo || bus.SEQ_IDX !== 4'(eidx) || bus.PC_INS !== 8'(epc)) begin
        errors++;
        $display("FAIL prog%0d cycle %0d outs=%h idx=%0d pc=%0d required outs=%h idx=%0d pc=%0d",
                 inject_start, c, o, bus.SEQ_IDX, bus.PC_INS, eo, eidx, epc);
      end
      tick();
    end
    bus.START = 1'b0;
    checks++;
    if (nb !== 64) begin
      errors++;
      $display("FAIL prog%0d beat_count got %0d required 64", inject_start, nb);
    end
  endtask

  task automatic test_stall();
    logic [7:0] o, eo;
    int eidx, epc;
    clear_rom();
    rom[0] = 32'h0000_0003;
    rom[1] = 32'h0000_0080;
    pulse_start();
    for (int c = 1; c <= 24; c++) begin
      bus.DP_READY = !(c >= 10 && c <= 12);
      #1;
      eo = 8'h04; eidx = 0; epc = 0;
      if (c >= 3 && c <= 21) begin
        eidx = (c < 10) ? c - 3 : (c <= 12 ? 7 : c - 6);
        eo[5] = bus.DP_READY;
        eo[4] = (c == 3);
      end else if (c >= 22) begin
        epc = 1;
        if (c == 24) eo = 8'h02;
      end
      o = outs();
      checks++;
      if (o !== eo || bus.SEQ_IDX !== 4'(eidx) || bus.PC_INS !== 8'(epc)) begin
        errors++;
        $display("FAIL stall cycle %0d outs=%h idx=%0d pc=%0d required outs=%h idx=%0d pc=%0d",
                 c, o, bus.SEQ_IDX, bus.PC_INS, eo, eidx, epc);
      end
      tick();
    end
    bus.DP_READY = 1'b1;
`ifdef SIMD_SEQ_PERF_EN
    checks++;
    if (bus.PERF_CYC !== 32'd23 || bus.PERF_STALL !== 16'd3) begin
      errors++;
      $display("FAIL perf_counters cyc=%0d stall=%0d required cyc=23 stall=3",
               bus.PERF_CYC, bus.PERF_STALL);
    end
`endif
  endtask

  task automatic test_illegal();
    logic [7:0] o, eo;
    clear_rom();
    rom[0] = 32'hABCD_EF09;
    rom[1] = 32'h0000_000A;
    rom[2] = 32'h1234_5655;
    bus.DP_READY = 1'b1;
    pulse_start();
    for (int c = 1; c <= 45; c++) begin
      #1;
      o = outs();
      eo = (c == 3) ? 8'h84 : (c == 21) ? 8'h44 : (c >= 39) ? 8'h01 : 8'h00;
      if (c == 3 || c == 21 || c >= 37) begin
        if (c == 37 || c == 38) eo = 8'h04;
        checks++;
        if (o !== eo || (c >= 37 && bus.PC_INS !== 8'd2)) begin
          errors++;
          $display("FAIL illegal cycle %0d outs=%h pc=%0d required outs=%h pc=2",
                   c, o, bus.PC_INS, eo);
        end
      end
      tick();
    end
    pulse_start();
    o = outs();
    checks++;
    if (o !== 8'h04 || bus.PC_INS !== 8'd0) begin
      errors++;
      $display("FAIL illegal_restart outs=%h pc=%0d required outs=04 pc=0", o, bus.PC_INS);
    end
    RSTN = 1'b1;
    tick();
    RSTN = 1'b0;
  endtask

  task automatic test_pc_overflow();
    int first_err;
    logic [7:0] o_last;
    logic [7:0] pc_last;
    logic [3:0] idx_last;
    for (int i = 0; i < 256; i++) rom[i] = {24'($urandom), 8'h09};
    bus.DP_READY = 1'b1;
    first_err = -1;
    o_last = 8'h00; pc_last = 8'h00; idx_last = 4'h0;
    pulse_start();
    for (int c = 1; c <= 4700; c++) begin
      #1;
      if (c == 4608) begin
        o_last = outs();
        pc_last = bus.PC_INS;
        idx_last = bus.SEQ_IDX;
      end
      if (bus.ERR === 1'b1) begin
        first_err = c;
        break;
      end
      tick();
    end
    checks++;
    if (first_err !== 4609) begin
      errors++;
      $display("FAIL ovf_err_cycle got %0d required 4609", first_err);
    end
    checks++;
    if (o_last !== 8'h84 || pc_last !== 8'd255 || idx_last !== 4'd15) begin
      errors++;
      $display("FAIL ovf_last_beat outs=%h pc=%0d idx=%0d required outs=84 pc=255 idx=15",
               o_last, pc_last, idx_last);
    end
    checks++;
    if (outs() !== 8'h01 || bus.PC_INS !== 8'd255) begin
      errors++;
      $display("FAIL ovf_errs outs=%h pc=%0d required outs=01 pc=255", outs(), bus.PC_INS);
    end
  endtask

  task automatic test_start_while_busy();
    test_program(1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RSTN = 1'b1;
    bus.START = 1'b0;
    bus.DP_READY = 1'b1;
    clear_rom();
    test_reset();
    test_program(1'b0);
    test_stall();
    test_illegal();
    test_pc_overflow();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
